// File: rtl/ofm_reader.sv
// Streams a finished output feature map out of the OFM RAM read port as INOUT_WIDTH-wide
// beats on a valid/ready stream with lane mask and last flag.
module ofm_reader #(
    parameter int DATA_WIDTH   = 16,
    parameter int INOUT_WIDTH  = 256,
    parameter int OFM_RAM_SIZE = 692224,
    parameter int ADDR_WIDTH   = $clog2(OFM_RAM_SIZE),
    localparam int W           = INOUT_WIDTH / DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [9:0]             ofm_size,
    input  logic [10:0]            num_filter,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [INOUT_WIDTH-1:0] rd_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [INOUT_WIDTH-1:0] m_data,
    output logic [W-1:0]           m_keep,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             fsm_state
);
    localparam int LW = $clog2(W);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, STREAM = 2'd2, FIN = 2'd3} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [9:0]              size_q;
    logic [10:0]             nf_q;
    logic [30:0]             total_q;
    logic [31:0]             issue_cnt;
    logic [31:0]             beats;
    logic [LW-1:0]           rem;
    logic [19:0]             size_sq;
    logic [30:0]             product;
    logic                    inflight;
    logic                    inflight_last;
    logic                    pop;
    logic                    issue_ok;
    logic [W-1:0]            push_keep;
    logic [INOUT_WIDTH-1:0]  lane_mask;
    logic [ADDR_WIDTH-1:0]   base_aligned;

    // Two-entry output FIFO; the head drives the stream directly.
    logic [INOUT_WIDTH-1:0]  mem_data [2];
    logic [W-1:0]            mem_keep [2];
    logic                    mem_last [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;

    assign size_sq      = {10'd0, size_q} * {10'd0, size_q};
    assign product      = {11'd0, size_sq} * {20'd0, nf_q};
    assign beats        = ({1'b0, total_q} + 32'(W - 1)) >> LW;
    assign rem          = total_q[LW-1:0];
    assign base_aligned = base_addr & ~ADDR_WIDTH'(W - 1);

    // Stream handshake: a beat transfers on any edge where m_valid & m_ready; while
    // m_valid is high and m_ready low, m_data/m_keep/m_last hold the same FIFO head.
    assign m_valid = (count != 2'd0);
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? mem_data[rd_ptr] : '0;
    assign m_keep  = m_valid ? mem_keep[rd_ptr] : '0;
    assign m_last  = m_valid ? mem_last[rd_ptr] : 1'b0;
    assign rd_addr = rd_addr_q;
    assign fsm_state = state;

    // Credit: buffered beats plus the one read in flight must leave a free slot after this pop.
    assign issue_ok = (state == STREAM) && (issue_cnt < beats) &&
                      (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    always_comb begin
        push_keep = '1;
        if (inflight_last && (rem != '0))
            push_keep = (W'(1) << rem) - W'(1);
        lane_mask = '0;
        for (int i = 0; i < W; i++)
            lane_mask[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{push_keep[i]}};
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = CALC;
            end
            CALC: begin
                busy       = 1'b1;
                state_next = (product == '0) ? FIN : STREAM;
            end
            STREAM: begin
                busy  = 1'b1;
                rd_en = issue_ok;
                if (pop && mem_last[rd_ptr])
                    state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rd_addr_q     <= '0;
            size_q        <= '0;
            nf_q          <= '0;
            total_q       <= '0;
            issue_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_keep[i] <= '0;
                mem_last[i] <= 1'b0;
            end
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                rd_addr_q <= base_aligned;
                size_q    <= ofm_size;
                nf_q      <= num_filter;
                issue_cnt <= '0;
            end
            if (state == CALC)
                total_q <= product;
            if (rd_en) begin
                issue_cnt <= issue_cnt + 32'd1;
                rd_addr_q <= rd_addr_q + ADDR_WIDTH'(W);
            end
            inflight      <= rd_en;
            inflight_last <= rd_en && (issue_cnt == beats - 32'd1);
            if (inflight) begin
                mem_data[wr_ptr] <= rd_data & lane_mask;
                mem_keep[wr_ptr] <= push_keep;
                mem_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule
